ysyx_22041752_dmem_resp: RTL

Data-memory responder at the far end of the data_sram interface driven by the execute stage (en / wen / addr / wdata). It decodes the unshifted byte-enable size code and aligns strobes and write data to the addressed 64-bit word. It performs the write, or returns the full aligned word one cycle later for the memory stage to extract. It also flags out-of-range and misaligned accesses, and zero-fills its storage after reset.

---
 rtl/ysyx_22041752_dmem_resp_pkg.sv | 21 ++
 rtl/ysyx_22041752_dmem_resp_lane_align.sv | 41 ++++
 rtl/ysyx_22041752_dmem_resp.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ysyx_22041752_dmem_resp_pkg.sv
// Shared constants and types for the data-memory responder.
package ysyx_22041752_dmem_resp_pkg;

    localparam int unsigned SRAM_ADDR_WD = 64;
    localparam int unsigned SRAM_DATA_WD = 64;
    localparam int unsigned SRAM_WEN_WD  = 8;

    localparam logic [SRAM_WEN_WD-1:0] SIZE_RD = 8'h00;
    localparam logic [SRAM_WEN_WD-1:0] SIZE_B  = 8'h01;
    localparam logic [SRAM_WEN_WD-1:0] SIZE_H  = 8'h03;
    localparam logic [SRAM_WEN_WD-1:0] SIZE_W  = 8'h0f;
    localparam logic [SRAM_WEN_WD-1:0] SIZE_D  = 8'hff;

    localparam logic [SRAM_ADDR_WD-1:0] DEFAULT_BASE = 64'h0000_0000_8000_0000;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/ysyx_22041752_dmem_resp_lane_align.sv
// Size-code decode plus strobe/data alignment to the byte offset within a 64-bit word.
module ysyx_22041752_dmem_lane_align
    import ysyx_22041752_dmem_resp_pkg::*;
(
    input  logic [SRAM_WEN_WD-1:0]  wen,
    input  logic [2:0]              b,
    input  logic [SRAM_DATA_WD-1:0] wdata,
    output logic                    size_legal,
    output logic                    misalign,
    output logic [7:0]              strb,
    output logic [SRAM_DATA_WD-1:0] data
);

    // Byte and read accesses can never be misaligned.
    always_comb begin
        size_legal = 1'b0;
        misalign   = 1'b0;
        case (wen)
            SIZE_RD: size_legal = 1'b1;
            SIZE_B:  size_legal = 1'b1;
            SIZE_H: begin
                size_legal = 1'b1;
                misalign   = b[0];
            end
            SIZE_W: begin
                size_legal = 1'b1;
                misalign   = |b[1:0];
            end
            SIZE_D: begin
                size_legal = 1'b1;
                misalign   = |b;
            end
            default: ;
        endcase
    end

    // Lanes shifted past byte 7 drop off the top.
    assign strb = wen << b;
    assign data = wdata << {b, 3'b000};

endmodule

// File: rtl/ysyx_22041752_dmem_resp.sv
// Data-memory responder: zero-fills after reset, then serves one-cycle reads and strobed writes.
module ysyx_22041752_dmem_resp
    import ysyx_22041752_dmem_resp_pkg::*;
#(
    parameter int unsigned              DEPTH          = 1024,
    parameter logic [SRAM_ADDR_WD-1:0]  BASE           = DEFAULT_BASE,
    parameter bit                       CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_sram_en,
    input  logic [SRAM_WEN_WD-1:0]  data_sram_wen,
    input  logic [SRAM_ADDR_WD-1:0] data_sram_addr,
    input  logic [SRAM_DATA_WD-1:0] data_sram_wdata,
    output logic [SRAM_DATA_WD-1:0] data_sram_rdata,
    output logic                    data_sram_rvalid,
    output logic                    data_sram_err,
    output logic                    init_busy
);

    localparam int unsigned           AW   = $clog2(DEPTH);
    localparam logic [SRAM_ADDR_WD-1:0] SPAN = SRAM_ADDR_WD'(DEPTH) << 3;
    localparam logic [AW-1:0]         LAST = AW'(DEPTH - 1);

    logic [SRAM_DATA_WD-1:0] mem [DEPTH];

    dmem_state_e             state, state_nx;
    logic [AW-1:0]           clr_idx, clr_idx_nx;
    logic [SRAM_DATA_WD-1:0] rdata_nx;
    logic                    rvalid_nx, err_nx, busy_nx;

    logic [SRAM_ADDR_WD-1:0] off;
    logic                    in_range;
    logic [AW-1:0]           idx;
    logic                    size_legal, misalign, fault;
    logic [7:0]              lane_strb;
    logic [SRAM_DATA_WD-1:0] lane_data;

    logic                    we;
    logic [AW-1:0]           waddr;
    logic [7:0]              wmask;
    logic [SRAM_DATA_WD-1:0] wdat;

    // Addresses below BASE wrap to huge offsets and fall out of range.
    assign off      = data_sram_addr - BASE;
    assign in_range = off < SPAN;
    assign idx      = off[AW+2:3];

    ysyx_22041752_dmem_lane_align u_lane_align (
        .wen        (data_sram_wen),
        .b          (data_sram_addr[2:0]),
        .wdata      (data_sram_wdata),
        .size_legal (size_legal),
        .misalign   (misalign),
        .strb       (lane_strb),
        .data       (lane_data)
    );

    assign fault = !in_range || !size_legal || misalign;

    // Next state, write-port mux and registered-output next values.
    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        rdata_nx   = data_sram_rdata;
        rvalid_nx  = 1'b0;
        err_nx     = 1'b0;
        we         = 1'b0;
        waddr      = idx;
        wmask      = lane_strb;
        wdat       = lane_data;
        case (state)
            ST_INIT: begin
                we    = 1'b1;
                waddr = clr_idx;
                wmask = 8'hff;
                wdat  = '0;
                if (clr_idx == LAST) begin
                    state_nx = ST_READY;
                end else begin
                    clr_idx_nx = clr_idx + AW'(1);
                end
            end
            ST_READY: begin
                if (data_sram_en) begin
                    if (fault) begin
                        err_nx = 1'b1;
                        if (data_sram_wen == SIZE_RD) begin
                            rvalid_nx = 1'b1;
                            rdata_nx  = '0;
                        end
                    end else if (data_sram_wen == SIZE_RD) begin
                        rvalid_nx = 1'b1;
                        rdata_nx  = mem[idx];
                    end else begin
                        we = 1'b1;
                    end
                end
            end
            default: state_nx = ST_INIT;
        endcase
        busy_nx = (state_nx == ST_INIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
            clr_idx          <= '0;
            data_sram_rdata  <= '0;
            data_sram_rvalid <= 1'b0;
            data_sram_err    <= 1'b0;
            init_busy        <= CLEAR_ON_RESET;
        end else begin
            state            <= state_nx;
            clr_idx          <= clr_idx_nx;
            data_sram_rdata  <= rdata_nx;
            data_sram_rvalid <= rvalid_nx;
            data_sram_err    <= err_nx;
            init_busy        <= busy_nx;
        end
    end

    // Single byte-masked write port shared by the fill and store paths.
    always_ff @(posedge clk) begin
        if (!reset && we) begin
            for (int k = 0; k < 8; k++) begin
                if (wmask[k]) begin
                    mem[waddr][8*k +: 8] <= wdat[8*k +: 8];
                end
            end
        end
    end

endmodule
